// File: rtl/serial_tx_scheduler.sv
// -----------------------------------------------------------------------------
// serial_tx_scheduler
//
// Purpose:
//   Sequencer/arbiter in front of the 10-bit parallel-in serial-out frame
//   shifter. Two requesters offer bytes over valid/ready. One byte is granted
//   at a time and held on sr_data for the whole frame. The block generates the
//   shifter controls:
//     - sr_clk    : one-cycle bit tick
//     - sr_en     : enable
//     - sr_finish : hold
//   After the frame the block enforces an idle gap of IDLE_GAP bit periods.
//
// Parameters:
//   CLK_DIV    : clk cycles per bit tick (>= 2)
//   FRAME_BITS : sr_clk pulses per frame (start + 8 data + stop)
//   IDLE_GAP   : bit periods of enforced gap after each frame (>= 0)
//
// Ports:
//   clk         in   clock, all logic on posedge
//   reset       in   synchronous, active-high
//   req0_valid  in   requester 0 has a byte
//   req0_data   in   requester 0 byte
//   req0_ready  out  requester 0 byte accepted this cycle when valid&ready
//   req1_valid  in   requester 1 has a byte
//   req1_data   in   requester 1 byte
//   req1_ready  out  requester 1 byte accepted this cycle when valid&ready
//   sr_clk      out  one-cycle bit tick to the shifter
//   sr_en       out  shifter enable, high for the whole SHIFT state
//   sr_finish   out  shifter hold, high in IDLE/GAP, low in SHIFT
//   sr_data     out  granted byte, stable from accept until the next accept
//   busy        out  high in SHIFT and GAP
//   grant_id    out  requester owning the current/last frame
//   frame_done  out  one-cycle pulse on return to IDLE
//
// Configuration macro:
//   TXSCHED_RR_EN : when defined, ties go to the requester named by a
//                   round-robin pointer. After each accept the pointer moves
//                   to the requester that was not granted. When undefined,
//                   req0 always wins ties.
// -----------------------------------------------------------------------------
module serial_tx_scheduler #(
    parameter int CLK_DIV    = 434,
    parameter int FRAME_BITS = 10,
    parameter int IDLE_GAP   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       sr_clk,
    output logic       sr_en,
    output logic       sr_finish,
    output logic [7:0] sr_data,
    output logic       busy,
    output logic       grant_id,
    output logic       frame_done
);

    localparam int BAUD_W  = $clog2(CLK_DIV);
    localparam int CNT_MAX = (FRAME_BITS > IDLE_GAP) ? FRAME_BITS : IDLE_GAP;
    // One counter serves as the bit counter in SHIFT and the gap counter in GAP.
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sr_clk_q, sr_clk_d;
    logic              sr_en_q, sr_en_d;
    logic              sr_finish_q, sr_finish_d;
    logic [7:0]        sr_data_q, sr_data_d;
    logic              busy_q, busy_d;
    logic              grant_q, grant_d;
    logic              frame_done_q, frame_done_d;
`ifdef TXSCHED_RR_EN
    logic              rr_ptr_q, rr_ptr_d;
`endif

    logic winner_s;
    logic any_valid_s;
    logic accept_s;
    logic baud_wrap_s;

    // Arbitration: pick the requester that wins this cycle from the valids.
    always_comb begin
        any_valid_s = req0_valid | req1_valid;
`ifdef TXSCHED_RR_EN
        if (req0_valid && req1_valid) begin
            winner_s = rr_ptr_q;
        end else if (req0_valid) begin
            winner_s = 1'b0;
        end else begin
            winner_s = 1'b1;
        end
`else
        if (req0_valid) begin
            winner_s = 1'b0;
        end else begin
            winner_s = 1'b1;
        end
`endif
    end

    // Handshake. Ready is held low while reset is asserted. A byte offered
    // during reset therefore stays pending and is taken on the first cycle
    // after release, instead of being lost to the reset.
    assign accept_s    = (state_q == ST_IDLE) && !reset && any_valid_s;
    assign req0_ready  = accept_s && req0_valid && (winner_s == 1'b0);
    assign req1_ready  = accept_s && req1_valid && (winner_s == 1'b1);
    assign baud_wrap_s = (baud_q == BAUD_W'(CLK_DIV - 1));

    // Next-state and next-output computation for the frame sequencer.
    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        cnt_d        = cnt_q;
        sr_clk_d     = 1'b0;
        sr_en_d      = sr_en_q;
        sr_finish_d  = sr_finish_q;
        sr_data_d    = sr_data_q;
        busy_d       = busy_q;
        grant_d      = grant_q;
        frame_done_d = 1'b0;
`ifdef TXSCHED_RR_EN
        rr_ptr_d     = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    sr_data_d   = winner_s ? req1_data : req0_data;
                    grant_d     = winner_s;
                    baud_d      = {BAUD_W{1'b0}};
                    cnt_d       = {CNT_W{1'b0}};
                    sr_en_d     = 1'b1;
                    sr_finish_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ST_SHIFT;
`ifdef TXSCHED_RR_EN
                    rr_ptr_d    = ~winner_s;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (baud_wrap_s) begin
                    baud_d   = {BAUD_W{1'b0}};
                    sr_clk_d = 1'b1;
                    if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                        // This edge emits the last bit tick of the frame.
                        cnt_d       = {CNT_W{1'b0}};
                        sr_en_d     = 1'b0;
                        sr_finish_d = 1'b1;
                        if (IDLE_GAP == 0) begin
                            state_d      = ST_IDLE;
                            busy_d       = 1'b0;
                            frame_done_d = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_GAP: begin
                if (baud_wrap_s) begin
                    baud_d = {BAUD_W{1'b0}};
                    if (cnt_q == CNT_W'(IDLE_GAP - 1)) begin
                        cnt_d        = {CNT_W{1'b0}};
                        state_d      = ST_IDLE;
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                // An illegal encoding falls back to a safe idle state.
                state_d     = ST_IDLE;
                baud_d      = {BAUD_W{1'b0}};
                cnt_d       = {CNT_W{1'b0}};
                sr_en_d     = 1'b0;
                sr_finish_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            baud_q       <= {BAUD_W{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            sr_clk_q     <= 1'b0;
            sr_en_q      <= 1'b0;
            sr_finish_q  <= 1'b1;
            sr_data_q    <= 8'h00;
            busy_q       <= 1'b0;
            grant_q      <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef TXSCHED_RR_EN
            rr_ptr_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            cnt_q        <= cnt_d;
            sr_clk_q     <= sr_clk_d;
            sr_en_q      <= sr_en_d;
            sr_finish_q  <= sr_finish_d;
            sr_data_q    <= sr_data_d;
            busy_q       <= busy_d;
            grant_q      <= grant_d;
            frame_done_q <= frame_done_d;
`ifdef TXSCHED_RR_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
        end
    end

    assign sr_clk     = sr_clk_q;
    assign sr_en      = sr_en_q;
    assign sr_finish  = sr_finish_q;
    assign sr_data    = sr_data_q;
    assign busy       = busy_q;
    assign grant_id   = grant_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_serial_tx_scheduler
//
// Structure:
//   - Reference model: each cycle it takes the sampled inputs and predicts every
//     DUT output from the frame timeline (cycles since the last accept).
//     Predictions go into a per-cycle queue. Each accepted frame also goes into
//     a frame queue.
//   - Monitor: pops the per-cycle predictions and compares them with the DUT.
//     On each frame_done it pops a frame record and checks id, data and latency.
//   - Driver: directed scenarios followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_serial_tx_scheduler;

    localparam int CD        = 4;
    localparam int FB        = 10;
    localparam int IG        = 1;
    localparam int EN_LEN    = FB * CD;        // cycles sr_en is high
    localparam int FRAME_LEN = (FB + IG) * CD; // cycles busy is high

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req1_ready;
    logic       sr_clk;
    logic       sr_en;
    logic       sr_finish;
    logic [7:0] sr_data;
    logic       busy;
    logic       grant_id;
    logic       frame_done;

    serial_tx_scheduler #(
        .CLK_DIV    (CD),
        .FRAME_BITS (FB),
        .IDLE_GAP   (IG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .sr_clk     (sr_clk),
        .sr_en      (sr_en),
        .sr_finish  (sr_finish),
        .sr_data    (sr_data),
        .busy       (busy),
        .grant_id   (grant_id),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       r0;
        logic       r1;
        logic       busy;
        logic       en;
        logic       fin;
        logic       sclk;
        logic       fd;
        logic       id;
        logic [7:0] data;
    } exp_t;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
        int         acc;
    } frm_t;

    exp_t oq[$];
    frm_t fq[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: predicts the outputs of cycle n from the inputs sampled in cycle n.
    initial begin : model
        logic       have;
        int         acc_c;
        logic       sh_id;
        logic [7:0] sh_data;
        logic       pend_id;
        logic [7:0] pend_data;
        logic       win;
        logic       ptr;
        exp_t       e;
        int         d;
        logic       idle;
        logic       any;
        have = 1'b0; acc_c = 0; sh_id = 1'b0; sh_data = 8'h00;
        pend_id = 1'b0; pend_data = 8'h00; ptr = 1'b0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            d = have ? (cyc - acc_c) : 100000;
            if (have && d == 1) begin
                sh_id   = pend_id;
                sh_data = pend_data;
            end
            e.busy = (d >= 1) && (d <= FRAME_LEN);
            e.en   = (d >= 1) && (d <= EN_LEN);
            e.fin  = !e.en;
            e.sclk = (d >= CD + 1) && (d <= EN_LEN + 1) && ((d - 1) % CD == 0);
            e.fd   = (d == FRAME_LEN + 1);
            e.id   = sh_id;
            e.data = sh_data;
            idle   = (d > FRAME_LEN);
            any    = req0_valid || req1_valid;
`ifdef TXSCHED_RR_EN
            win = (req0_valid && req1_valid) ? ptr : (req0_valid ? 1'b0 : 1'b1);
`else
            win = req0_valid ? 1'b0 : 1'b1;
`endif
            e.r0 = idle && !reset && any && (win == 1'b0);
            e.r1 = idle && !reset && any && (win == 1'b1);
            oq.push_back(e);
            if (reset) begin
                have = 1'b0; sh_id = 1'b0; sh_data = 8'h00; ptr = 1'b0;
                fq.delete();
            end else if (idle && any) begin
                have      = 1'b1;
                acc_c     = cyc;
                pend_id   = win;
                pend_data = win ? req1_data : req0_data;
                ptr       = ~win;
                fq.push_back('{win, pend_data, cyc});
            end
        end
    end

    // Monitor: compares the DUT outputs against the queued predictions.
    initial begin : monitor
        exp_t e;
        frm_t f;
        @(posedge clk);
        forever begin
            @(negedge clk);
            #1;
            if (oq.size() == 0) begin
                chk("pred_queue_nonempty", 32'd0, 32'd1);
            end else begin
                e = oq.pop_front();
                chk("req0_ready", {31'd0, req0_ready}, {31'd0, e.r0});
                chk("req1_ready", {31'd0, req1_ready}, {31'd0, e.r1});
                chk("busy",       {31'd0, busy},       {31'd0, e.busy});
                chk("sr_en",      {31'd0, sr_en},      {31'd0, e.en});
                chk("sr_finish",  {31'd0, sr_finish},  {31'd0, e.fin});
                chk("sr_clk",     {31'd0, sr_clk},     {31'd0, e.sclk});
                chk("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
                chk("grant_id",   {31'd0, grant_id},   {31'd0, e.id});
                chk("sr_data",    {24'd0, sr_data},    {24'd0, e.data});
            end
            if (frame_done === 1'b1) begin
                if (fq.size() == 0) begin
                    chk("frame_done_expected", 32'd1, 32'd0);
                end else begin
                    f = fq.pop_front();
                    chk("frame_id",      {31'd0, grant_id}, {31'd0, f.id});
                    chk("frame_data",    {24'd0, sr_data},  {24'd0, f.data});
                    chk("frame_latency", cyc - f.acc,       FRAME_LEN + 1);
                end
            end
        end
    end

    task automatic step(input logic v0, input logic [7:0] a0,
                        input logic v1, input logic [7:0] a1, input logic rst);
        @(posedge clk);
        #1;
        req0_valid = v0;
        req0_data  = a0;
        req1_valid = v1;
        req1_data  = a1;
        reset      = rst;
    endtask

    // Driver: directed scenarios, then randomized traffic, then drain.
    initial begin : driver
        repeat (3) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        // Single req0 frame. Data wiggles mid-frame. Valid is raised and then dropped while not ready.
        step(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0);
        repeat (4)  step(1'b0, 8'($urandom), 1'b0, 8'($urandom), 1'b0);
        repeat (16) step(1'b1, 8'($urandom), 1'b0, 8'($urandom), 1'b0);
        repeat (40) step(1'b0, 8'($urandom), 1'b0, 8'($urandom), 1'b0);
        // Both requesters held valid: the arbitration order is observed.
        repeat (2) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        repeat (4 * (FRAME_LEN + 1) + 2) step(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
        repeat (50) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        // req1 alone and held: back-to-back frames. Data changes every cycle.
        repeat (3 * (FRAME_LEN + 1) + 5) step(1'b0, 8'h00, 1'b1, 8'($urandom), 1'b0);
        repeat (50) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        // Reset in the 5th sr_clk cycle with req1 pending.
        repeat (2) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h3C, 1'b0, 8'h00, 1'b0);
        repeat (4 * CD) step(1'b0, 8'($urandom), 1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1, 8'h77, 1'b1);
        step(1'b0, 8'h00, 1'b1, 8'h77, 1'b0);
        repeat (60) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 2) == 0, 8'($urandom),
                 $urandom_range(0, 2) == 0, 8'($urandom), 1'b0);
        end
        repeat (60) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        #2;
        chk("frames_all_completed", fq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
